// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// controller states and the default operand width.
package seq_mult_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one partial product per cycle, fixed
// WIDTH-cycle latency, unsigned or two's-complement operands, valid/ready on both sides.
module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out
);

    localparam int             CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST_STEP = CW'(WIDTH - 1);

    state_t               r_state;
    logic [CW-1:0]        r_count;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic                 r_signed;
    logic                 r_outValid;

    logic                 w_accept;
    logic                 w_lastStep;
    logic [2*WIDTH-1:0]   w_extIn1;
    logic [2*WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0]   w_accNext;

    assign in_ready   = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_lastStep = (r_count == LAST_STEP);

    assign w_extIn1 = signed_mode ? {{WIDTH{in1[WIDTH-1]}}, in1}
                                  : {{WIDTH{1'b0}}, in1};

    // The multiplicand register is pre-shifted each step, so the addend for step i
    // is already ext(in1) << i; the multiplier shifts right so bit 0 is always bit i.
    assign w_addend  = r_mplier[0] ? r_mcand : '0;

    // The MSB of a two's-complement multiplier carries weight -2^(WIDTH-1).
    assign w_accNext = (w_lastStep && r_signed) ? (r_acc - w_addend)
                                                : (r_acc + w_addend);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_signed   <= 1'b0;
            r_outValid <= 1'b0;
        end else if (w_accept) begin
            r_state    <= BUSY;
            r_count    <= '0;
            r_acc      <= '0;
            r_mcand    <= w_extIn1;
            r_mplier   <= in2;
            r_signed   <= signed_mode;
            r_outValid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                end
                BUSY: begin
                    r_acc    <= w_accNext;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + CW'(1);
                    if (w_lastStep) begin
                        r_state    <= DONE;
                        r_outValid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state    <= IDLE;
                        r_outValid <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_outValid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_outValid;
    assign out       = r_outValid ? r_acc : '0;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier (WIDTH=8): directed vectors push expected
// products into a queue, an independent monitor pops on every output handshake.
module tb_seq_multiplier;

    localparam int WIDTH = 8;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    in1;
    logic [WIDTH-1:0]    in2;
    logic                signed_mode;
    logic                out_valid;
    logic                out_ready;
    logic [2*WIDTH-1:0]  out;

    int                  nCompared;
    int                  nMismatched;
    logic [2*WIDTH-1:0]  expQ[$];

    seq_multiplier #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in1         (in1),
        .in2         (in2),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out         (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Called at a drive point (just after a falling edge). Holds in_valid until
    // in_ready is seen, pushes the expected product, and returns at the falling
    // edge after the accepting rising edge with in_valid dropped.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic sgn, input logic [2*WIDTH-1:0] expected,
                                 output int waited, output logic wasDone);
        in1         = a;
        in2         = b;
        signed_mode = sgn;
        in_valid    = 1'b1;
        waited      = 0;
        #1;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 32'(in_ready), 32'd1);
        end
        wasDone = out_valid;
        expQ.push_back(expected);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int cycles;
        cycles = 0;
        while (expQ.size() != 0 && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput(name, 32'(expQ.size()), 32'd0);
        @(negedge clk);
    endtask

    // Monitor: compares every presented product against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_product", 32'(out), 32'hDEAD_BEEF);
                end else begin
                    checkOutput("product", 32'(out), 32'(expQ.pop_front()));
                end
            end else if (!out_valid) begin
                checkOutput("out_zero_when_idle", 32'(out), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int   waited;
        logic wasDone;
        int   lat;

        nCompared   = 0;
        nMismatched = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in1         = '0;
        in2         = '0;
        signed_mode = 1'b0;
        out_ready   = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out", 32'(out), 32'd0);

        // Release reset and offer 255*255 at once: accepted on the first rising edge
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'd255, 8'd255, 1'b0, 16'hFE01, waited, wasDone);
        checkOutput("first_accept_wait", 32'(waited), 32'd0);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) checkOutput("busy_in_ready", 32'(in_ready), 32'd0);
        end while (!out_valid && lat < 50);
        checkOutput("latency_edges", 32'(lat), 32'(WIDTH));
        @(posedge clk);
        #1;
        checkOutput("idle_after_done_in_ready", 32'(in_ready), 32'd1);
        checkOutput("idle_after_done_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        waitDrain("drain_unsigned_max");

        // Signed corner cases
        applyStimulus(8'h80, 8'h80, 1'b1, 16'h4000, waited, wasDone);
        waitDrain("drain_signed_min_min");
        applyStimulus(8'hFF, 8'h01, 1'b1, 16'hFFFF, waited, wasDone);
        waitDrain("drain_signed_m1_p1");
        applyStimulus(8'h7F, 8'hFE, 1'b1, 16'hFF02, waited, wasDone);
        waitDrain("drain_signed_127_m2");

        // Backpressure: product must sit still while out_ready is low
        out_ready = 1'b0;
        applyStimulus(8'd13, 8'd11, 1'b0, 16'h008F, waited, wasDone);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            #1;
            lat++;
        end
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_out", 32'(out), 32'h008F);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
            #1;
        end
        out_ready = 1'b1;
        waitDrain("drain_backpressure");

        // Back-to-back: 3*4 offered while 5*6 is busy, accepted straight from DONE
        applyStimulus(8'd5, 8'd6, 1'b0, 16'h001E, waited, wasDone);
        applyStimulus(8'd3, 8'd4, 1'b0, 16'h000C, waited, wasDone);
        checkOutput("b2b_accept_in_done", 32'(wasDone), 32'd1);
        #1;
        checkOutput("b2b_busy_no_idle", 32'(in_ready), 32'd0);
        @(negedge clk);
        waitDrain("drain_back_to_back");

        // Reset in the middle of 200*200 discards it
        applyStimulus(8'd200, 8'd200, 1'b0, 16'h9C40, waited, wasDone);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        expQ.delete();
        #1;
        checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'd2, 8'd3, 1'b0, 16'h0006, waited, wasDone);
        waitDrain("drain_after_reset");

        // In-flight noise on every input must not disturb captured operands
        applyStimulus(8'hB7, 8'h5D, 1'b0, 16'h427B, waited, wasDone);
        for (int i = 0; i < 6; i++) begin
            in1         = 8'($urandom);
            in2         = 8'($urandom);
            signed_mode = 1'($urandom);
            in_valid    = 1'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        waitDrain("drain_noise_unsigned");
        applyStimulus(8'hFD, 8'h07, 1'b1, 16'hFFEB, waited, wasDone);
        for (int i = 0; i < 6; i++) begin
            in1         = 8'($urandom);
            in2         = 8'($urandom);
            signed_mode = 1'($urandom);
            in_valid    = 1'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        waitDrain("drain_noise_signed");

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
